// File: rtl/mac_pe_pkg.sv
// Shared definitions for the streaming MAC PE: Booth radix-4 digit selects,
// partial-product count, default accumulator margin and saturation limits.
package mac_pe_pkg;

    typedef enum logic [2:0] {
        BOOTH_ZERO = 3'd0,
        BOOTH_POS1 = 3'd1,
        BOOTH_POS2 = 3'd2,
        BOOTH_NEG2 = 3'd3,
        BOOTH_NEG1 = 3'd4
    } booth_sel_t;

    localparam int DEFAULT_W    = 16;
    localparam int ACC_W_MARGIN = 8;
    localparam int MAX_ACC_W    = 256;

    function automatic int pp_count(input int w);
        return w / 2;
    endfunction

    // Triplet is {b[2i+1], b[2i], b[2i-1]}
    function automatic booth_sel_t booth_encode(input logic [2:0] bits);
        case (bits)
            3'b001, 3'b010: return BOOTH_POS1;
            3'b011:         return BOOTH_POS2;
            3'b100:         return BOOTH_NEG2;
            3'b101, 3'b110: return BOOTH_NEG1;
            default:        return BOOTH_ZERO;
        endcase
    endfunction

    function automatic logic [MAX_ACC_W-1:0] sat_pos(input int acc_w);
        logic [MAX_ACC_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_ACC_W; i++) begin
            if (i < acc_w - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Only the low acc_w bits are meaningful: sign bit set, all others clear
    function automatic logic [MAX_ACC_W-1:0] sat_neg(input int acc_w);
        return ~sat_pos(acc_w);
    endfunction

endpackage

// File: rtl/booth_csa_tree.sv
// Combinational radix-4 Booth multiplier front end: W/2 partial products
// compressed by a carry-save chain into two rows whose sum is a*b mod 2^(2W).
module booth_csa_tree
    import mac_pe_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_row0,
    output logic [2*W-1:0] o_row1
);
    localparam int NPP = pp_count(W);

    logic [2*W-1:0] w_a_ext;
    logic [W:0]     w_bx;
    logic [2*W-1:0] w_pp [NPP];

    assign w_a_ext = {{W{i_a[W-1]}}, i_a};
    assign w_bx    = {i_b, 1'b0};

    // Partial products: Booth digit times sign-extended a, weighted by 4^i
    always_comb begin
        logic [2*W-1:0] v_mag;
        for (int i = 0; i < NPP; i++) begin
            case (booth_encode(w_bx[2*i +: 3]))
                BOOTH_POS1: v_mag = w_a_ext;
                BOOTH_POS2: v_mag = w_a_ext << 1;
                BOOTH_NEG1: v_mag = -w_a_ext;
                BOOTH_NEG2: v_mag = -(w_a_ext << 1);
                default:    v_mag = '0;
            endcase
            w_pp[i] = v_mag << (2*i);
        end
    end

    // 3:2 carry-save reduction down to two rows
    always_comb begin
        logic [2*W-1:0] v_r0;
        logic [2*W-1:0] v_r1;
        logic [2*W-1:0] v_s;
        logic [2*W-1:0] v_c;
        v_r0 = w_pp[0];
        v_r1 = w_pp[1];
        for (int i = 2; i < NPP; i++) begin
            v_s  = v_r0 ^ v_r1 ^ w_pp[i];
            v_c  = ((v_r0 & v_r1) | (v_r0 & w_pp[i]) | (v_r1 & w_pp[i])) << 1;
            v_r0 = v_s;
            v_r1 = v_c;
        end
        o_row0 = v_r0;
        o_row1 = v_r1;
    end

endmodule

// File: rtl/mac_pe_stream.sv
// Two-stage streaming signed MAC PE with frame framing and operand forwarding.
// Build option: define MAC_PE_SAT_EN to saturate the accumulator instead of wrapping.
module mac_pe_stream
    import mac_pe_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int ACC_W = 2*W + ACC_W_MARGIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             in_clr,
    input  logic             in_last,
    output logic [W-1:0]     a_out,
    output logic [W-1:0]     b_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);
`ifdef MAC_PE_SAT_EN
    localparam logic [ACC_W-1:0] SAT_POS = ACC_W'(sat_pos(ACC_W));
    localparam logic [ACC_W-1:0] SAT_NEG = ACC_W'(sat_neg(ACC_W));
`endif

    logic             w_en;
    logic [2*W-1:0]   w_row0;
    logic [2*W-1:0]   w_row1;
    logic [2*W-1:0]   w_prod;
    logic [ACC_W-1:0] w_p;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_acc_n;
    logic             w_ovf_add;
    logic             w_ovf_n;

    logic [2*W-1:0]   r_row0;
    logic [2*W-1:0]   r_row1;
    logic             r_s1_valid;
    logic             r_s1_clr;
    logic             r_s1_last;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [W-1:0]     r_a_out;
    logic [W-1:0]     r_b_out;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_acc;
    logic             r_out_ovf;

    booth_csa_tree #(.W(W)) u_tree (
        .i_a    (a),
        .i_b    (b),
        .o_row0 (w_row0),
        .o_row1 (w_row1)
    );

    // A held result blocks the whole pipe
    assign w_en     = ~(r_out_valid & ~out_ready);
    assign in_ready = w_en;

    assign w_prod = r_row0 + r_row1;
    assign w_p    = {{(ACC_W-2*W){w_prod[2*W-1]}}, w_prod};

    // Accumulate with signed-overflow detection, optional clamping
    always_comb begin
        w_base    = r_s1_clr ? '0 : r_acc;
        w_sum     = w_base + w_p;
        w_ovf_add = (w_base[ACC_W-1] == w_p[ACC_W-1]) && (w_sum[ACC_W-1] != w_base[ACC_W-1]);
        w_ovf_n   = (r_s1_clr ? 1'b0 : r_ovf) | w_ovf_add;
`ifdef MAC_PE_SAT_EN
        if (w_ovf_add) begin
            w_acc_n = w_base[ACC_W-1] ? SAT_NEG : SAT_POS;
        end else begin
            w_acc_n = w_sum;
        end
`else
        w_acc_n = w_sum;
`endif
    end

    // S1: capture product rows, framing bits and forwarded operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row0     <= '0;
            r_row1     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_clr   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_a_out    <= '0;
            r_b_out    <= '0;
        end else if (w_en) begin
            r_row0     <= w_row0;
            r_row1     <= w_row1;
            r_s1_valid <= in_valid;
            r_s1_clr   <= in_clr;
            r_s1_last  <= in_last;
            if (in_valid) begin
                r_a_out <= a;
                r_b_out <= b;
            end
        end
    end

    // S2: accumulator update and result hand-off; a completing frame reloads out_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            if (w_en && r_s1_valid) begin
                if (r_s1_last) begin
                    r_out_acc   <= w_acc_n;
                    r_out_ovf   <= w_ovf_n;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_ovf       <= 1'b0;
                end else begin
                    r_acc <= w_acc_n;
                    r_ovf <= w_ovf_n;
                end
            end
        end
    end

    assign a_out     = r_a_out;
    assign b_out     = r_b_out;
    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_ovf   = r_out_ovf;

endmodule
